signal_indicator_mc: RTL and testbench

Multi-channel successor to the single-channel signal activity indicator. Each of N_CH asynchronous inputs is synchronised and edge-detected. A channel is declared present only after N_EDGES transitions, each within C_MAX clocks of the previous one. It is declared absent after C_MAX clocks with no transition. Per-channel change pulses, a sticky loss flag with clear, and an aggregate interrupt go to the status/CPU register block.

---
 rtl/signal_indicator_mc.sv | 190 +++++++++++++++++++
 tb/tb_signal_indicator_mc.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/signal_indicator_mc.sv
//------------------------------------------------------------------------------
// signal_indicator_mc
//
// Multi-channel signal activity indicator. Each of N_CH asynchronous inputs
// is brought into the clk domain through a two-flop synchroniser and
// edge-detected (both polarities). A channel is declared present after
// N_EDGES transitions, each arriving within C_MAX clocks of the previous one.
// It is declared absent once C_MAX consecutive clocks pass without a
// transition. Losing a present channel raises a sticky per-channel lost flag.
// The OR of all lost flags drives a registered interrupt.
//
// Ports:
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   in        in   [N_CH] monitored signals, asynchronous to clk
//   out       out  [N_CH] per-channel presence (1 = present)
//   changed   out  [N_CH] one-cycle pulse, coincident with each out[i] toggle
//   lost      out  [N_CH] sticky PRESENT -> ABSENT flag
//   lost_clr  in   [N_CH] per-channel clear for lost (set has priority)
//   irq       out  OR of all lost bits, registered
//------------------------------------------------------------------------------
module signal_indicator_mc #(
   parameter int N_CH    = 4,
   parameter int C_MAX   = 1000,
   parameter int N_EDGES = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [N_CH-1:0] in,
   output logic [N_CH-1:0] out,
   output logic [N_CH-1:0] changed,
   output logic [N_CH-1:0] lost,
   input  logic [N_CH-1:0] lost_clr,
   output logic            irq
);

   localparam int CW = $clog2(C_MAX + 1);
   localparam int EW = $clog2(N_EDGES + 1);

   localparam logic [CW-1:0] CNT_SAT   = CW'(C_MAX);
   localparam logic [CW-1:0] CNT_LAST  = CW'(C_MAX - 1);
   localparam logic [EW-1:0] ECNT_ONE  = EW'(1);
   localparam logic [EW-1:0] ECNT_LAST = EW'(N_EDGES - 1);

   typedef enum logic [1:0] {
      ST_ABSENT  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   // Timeout counter step: clear on an edge, otherwise count up and
   // saturate at C_MAX so a long-idle channel never wraps.
   function automatic logic [CW-1:0] cnt_step(input logic edge_i,
                                              input logic [CW-1:0] cnt_i);
      logic [CW-1:0] r;
      if (edge_i) begin
         r = '0;
      end else if (cnt_i < CNT_SAT) begin
         r = cnt_i + CW'(1);
      end else begin
         r = CNT_SAT;
      end
      return r;
   endfunction

   logic [N_CH-1:0] out_w;
   logic [N_CH-1:0] changed_w;
   logic [N_CH-1:0] lost_d;
   logic [N_CH-1:0] lost_q;
   logic            irq_q;

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      logic          s1_q;
      logic          s2_q;
      logic          prev_q;
      logic          edge_w;
      logic          timeout_w;
      logic          lost_set_w;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic [EW-1:0] ecnt_q;
      state_t        state_q;
      logic          out_q;
      logic          changed_q;

      // Synchroniser and edge history. prev resets to 0, so an input that is
      // already high at reset release produces exactly one edge.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            s1_q   <= in[ch];
            s2_q   <= s1_q;
            prev_q <= s2_q;
            cnt_q  <= cnt_d;
         end
      end

      assign edge_w = s2_q ^ prev_q;
      assign cnt_d  = cnt_step(edge_w, cnt_q);

      // Fires on the C_MAX-th edgeless cycle after the last edge cycle. A
      // saturated counter never matches, so an idle ABSENT channel is inert.
      assign timeout_w = !edge_w && (cnt_q == CNT_LAST);

      assign lost_set_w = (state_q == ST_PRESENT) && timeout_w;

      // Presence FSM. out and changed are registered alongside the state so
      // changed pulses in the same cycle that out takes its new value.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            state_q   <= ST_ABSENT;
            ecnt_q    <= '0;
            out_q     <= 1'b0;
            changed_q <= 1'b0;
         end else begin
            changed_q <= 1'b0;
            unique case (state_q)
               ST_ABSENT: begin
                  if (edge_w) begin
                     if (N_EDGES == 1) begin
                        state_q   <= ST_PRESENT;
                        ecnt_q    <= '0;
                        out_q     <= 1'b1;
                        changed_q <= 1'b1;
                     end else begin
                        state_q <= ST_ACQUIRE;
                        ecnt_q  <= ECNT_ONE;
                     end
                  end
               end
               ST_ACQUIRE: begin
                  if (edge_w) begin
                     // ecnt + 1 == N_EDGES, written without a widening add
                     if (ecnt_q == ECNT_LAST) begin
                        state_q   <= ST_PRESENT;
                        ecnt_q    <= '0;
                        out_q     <= 1'b1;
                        changed_q <= 1'b1;
                     end else begin
                        ecnt_q <= ecnt_q + EW'(1);
                     end
                  end else if (timeout_w) begin
                     state_q <= ST_ABSENT;
                     ecnt_q  <= '0;
                  end
               end
               ST_PRESENT: begin
                  if (timeout_w) begin
                     state_q   <= ST_ABSENT;
                     out_q     <= 1'b0;
                     changed_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_ABSENT;
                  ecnt_q  <= '0;
                  out_q   <= 1'b0;
               end
            endcase
         end
      end

      // Set has priority over clear; a held clear still lets a new loss in.
      assign lost_d[ch]    = lost_set_w | (lost_q[ch] & ~lost_clr[ch]);
      assign out_w[ch]     = out_q;
      assign changed_w[ch] = changed_q;
   end

   // irq is fed from the next-state lost vector so it moves on the same
   // clock as lost rather than one cycle behind it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lost_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         lost_q <= lost_d;
         irq_q  <= |lost_d;
      end
   end

   assign out     = out_w;
   assign changed = changed_w;
   assign lost    = lost_q;
   assign irq     = irq_q;

endmodule

// File: tb/tb_signal_indicator_mc.sv
//------------------------------------------------------------------------------
// tb_signal_indicator_mc
//
// Directed bench for signal_indicator_mc with default parameters (4 channels,
// C_MAX = 1000, N_EDGES = 4), 50 ns clock. Inputs are driven and outputs are
// sampled 1 ns after the rising edge. An input change driven just after clock
// P0 is registered by the FSM at clock P0+3.
//------------------------------------------------------------------------------
module tb_signal_indicator_mc;

   localparam int N_CH    = 4;
   localparam int C_MAX   = 1000;
   localparam int N_EDGES = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] in_s = 4'b0000;
   logic [3:0] lost_clr = 4'b0000;
   logic [3:0] out;
   logic [3:0] changed;
   logic [3:0] lost;
   logic       irq;

   signal_indicator_mc #(
      .N_CH    (N_CH),
      .C_MAX   (C_MAX),
      .N_EDGES (N_EDGES)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .in       (in_s),
      .out      (out),
      .changed  (changed),
      .lost     (lost),
      .lost_clr (lost_clr),
      .irq      (irq)
   );

   always #25 clk = ~clk;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [3:0] in_v;
      logic [3:0] clr_v;
      int         ncyc;
      logic [3:0] e_out;
      logic [3:0] e_chg;
      logic [3:0] e_lost;
      logic       e_irq;
   } vec_t;

   vec_t tv [11];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] eo, input logic [3:0] ec,
                          input logic [3:0] el, input logic ei);
      chk({tag, ".out"}, 32'(out), 32'(eo));
      chk({tag, ".changed"}, 32'(changed), 32'(ec));
      chk({tag, ".lost"}, 32'(lost), 32'(el));
      chk({tag, ".irq"}, 32'(irq), 32'(ei));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // n toggles of the masked inputs, gap clocks apart; returns right after
   // the last toggle is driven.
   task automatic toggle_n(input logic [3:0] mask, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         in_s = in_s ^ mask;
         if (i < n - 1) tick(gap);
      end
   endtask

   logic [1:0] seen;

   initial begin
      // Scenario 1/2 table: acquire channel 0 with toggles 40 clk apart, then
      // let it time out exactly 1000 clk after its last edge cycle, then clear.
      tv[0]  = '{4'b0001, 4'b0000, 40,  4'b0000, 4'b0000, 4'b0000, 1'b0};
      tv[1]  = '{4'b0000, 4'b0000, 40,  4'b0000, 4'b0000, 4'b0000, 1'b0};
      tv[2]  = '{4'b0001, 4'b0000, 40,  4'b0000, 4'b0000, 4'b0000, 1'b0};
      tv[3]  = '{4'b0000, 4'b0000, 2,   4'b0000, 4'b0000, 4'b0000, 1'b0};
      tv[4]  = '{4'b0000, 4'b0000, 1,   4'b0001, 4'b0001, 4'b0000, 1'b0};
      tv[5]  = '{4'b0000, 4'b0000, 1,   4'b0001, 4'b0000, 4'b0000, 1'b0};
      tv[6]  = '{4'b0000, 4'b0000, 998, 4'b0001, 4'b0000, 4'b0000, 1'b0};
      tv[7]  = '{4'b0000, 4'b0000, 1,   4'b0000, 4'b0001, 4'b0001, 1'b1};
      tv[8]  = '{4'b0000, 4'b0000, 1,   4'b0000, 4'b0000, 4'b0001, 1'b1};
      tv[9]  = '{4'b0000, 4'b0001, 1,   4'b0000, 4'b0000, 4'b0000, 1'b0};
      tv[10] = '{4'b0000, 4'b0000, 1,   4'b0000, 4'b0000, 4'b0000, 1'b0};

      resetn   = 1'b0;
      in_s     = 4'b0000;
      lost_clr = 4'b0000;
      tick(20);
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      resetn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         in_s     = tv[i].in_v;
         lost_clr = tv[i].clr_v;
         tick(tv[i].ncyc);
         chk_all($sformatf("vec%0d", i), tv[i].e_out, tv[i].e_chg, tv[i].e_lost, tv[i].e_irq);
      end

      // Scenario 3: three edges then silence, channel never becomes present
      // and the abandoned acquisition does not flag a loss.
      toggle_n(4'b0001, 3, 40);
      seen = 2'b00;
      for (int i = 0; i < 1100; i++) begin
         tick(1);
         seen = seen | {out[0], lost[0]};
      end
      chk("s3_silence_out_lost", 32'(seen), 32'd0);
      toggle_n(4'b0001, 3, 40);
      tick(40);
      chk("s3_three_fresh", 32'(out), 32'd0);
      in_s[0] = ~in_s[0];
      tick(2);
      chk("s3_fourth_pre", 32'(out), 32'd0);
      tick(1);
      chk("s3_fourth_out", 32'(out), 32'b0001);
      chk("s3_fourth_chg", 32'(changed), 32'b0001);

      // Scenario 4: 999 edgeless cycles between edges keeps presence,
      // 1000 edgeless cycles drops it on that cycle.
      tick(997);
      chk("s4_before_gap999", 32'(out), 32'b0001);
      in_s[0] = ~in_s[0];
      tick(3);
      chk("s4_gap999_out", 32'(out), 32'b0001);
      tick(1);
      chk_all("s4_gap999_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);
      tick(997);
      chk("s4_before_gap1000", 32'(out), 32'b0001);
      in_s[0] = ~in_s[0];
      tick(1);
      chk("s4_gap1000_m1", 32'(out), 32'b0001);
      tick(1);
      chk_all("s4_gap1000_drop", 4'b0000, 4'b0001, 4'b0001, 1'b1);
      tick(1);
      chk_all("s4_late_edge", 4'b0000, 4'b0000, 4'b0001, 1'b1);
      lost_clr = 4'b0001;
      tick(1);
      chk_all("s4_clear", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      lost_clr = 4'b0000;

      // Scenario 5: clear on the same clock as a loss (set wins), then
      // per-channel clears leave the other channel's flag alone.
      in_s   = 4'b0000;
      resetn = 1'b0;
      tick(3);
      chk_all("reset2", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      resetn = 1'b1;
      tick(2);
      toggle_n(4'b0011, 4, 40);
      tick(3);
      chk_all("s5_present", 4'b0011, 4'b0011, 4'b0000, 1'b0);
      tick(999);
      chk_all("s5_hold", 4'b0011, 4'b0000, 4'b0000, 1'b0);
      lost_clr = 4'b0001;
      tick(1);
      chk_all("s5_set_wins", 4'b0000, 4'b0011, 4'b0011, 1'b1);
      lost_clr = 4'b0000;
      tick(2);
      chk("s5_sticky", 32'(lost), 32'b0011);
      lost_clr = 4'b0001;
      tick(1);
      chk("s5_clr0_lost", 32'(lost), 32'b0010);
      chk("s5_clr0_irq", 32'(irq), 32'd1);
      lost_clr = 4'b0000;
      tick(1);
      chk("s5_ch1_kept", 32'(lost), 32'b0010);
      lost_clr = 4'b0010;
      tick(1);
      chk("s5_clr1_lost", 32'(lost), 32'b0000);
      chk("s5_clr1_irq", 32'(irq), 32'd0);
      lost_clr = 4'b0000;

      // Scenario 6: channel 1 lost, channels 0 and 2 present, then an
      // asynchronous reset between clock edges and a fresh reacquisition.
      toggle_n(4'b0010, 4, 40);
      tick(3);
      chk("s6_ch1_present", 32'(out), 32'b0010);
      tick(1000);
      chk_all("s6_ch1_lost", 4'b0000, 4'b0010, 4'b0010, 1'b1);
      toggle_n(4'b0101, 4, 40);
      tick(3);
      chk_all("s6_ch02_present", 4'b0101, 4'b0101, 4'b0010, 1'b1);
      tick(1);
      chk("s6_chg_clear", 32'(changed), 32'd0);
      #10;
      resetn = 1'b0;
      #1;
      chk_all("s6_async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick(2);
      resetn = 1'b1;
      tick(1);
      toggle_n(4'b0101, 3, 40);
      tick(40);
      chk("s6_three_after_reset", 32'(out), 32'd0);
      in_s = in_s ^ 4'b0101;
      tick(2);
      chk("s6_fourth_pre", 32'(out), 32'd0);
      tick(1);
      chk_all("s6_reacquired", 4'b0101, 4'b0101, 4'b0000, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
